// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write sequencer: FSM states,
// the fixed init command ROM and the long-execution command classifier.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_LOAD,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT,
        ST_IDLE
    } lcd_state_t;

    localparam int unsigned LCD_INIT_LEN = 4;

    // Function set 8-bit/2-line, display on, clear, entry mode increment.
    localparam logic [7:0] LCD_INIT_CMDS [LCD_INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    function automatic logic lcd_is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
    endfunction

    function automatic int unsigned lcd_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Shared down-counter for all timed sequencer states: loaded with N-1 on state
// entry, done while it reads zero, and it never wraps below zero.
module lcd_delay_counter #(
    parameter int unsigned  W       = 20,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_write_sequencer.sv
// HD44780 write-only bus sequencer: power-up delay, fixed init sequence, then
// valid/ready byte writes with setup/EN/hold timing and per-command execution waits.
module lcd_write_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned POWERUP_CYC    = 750000,
    parameter int unsigned SETUP_CYC      = 3,
    parameter int unsigned EN_CYC         = 25,
    parameter int unsigned HOLD_CYC       = 3,
    parameter int unsigned CMD_WAIT_CYC   = 2000,
    parameter int unsigned CLEAR_WAIT_CYC = 82000
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       init_done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);

    localparam int unsigned MAX_CYC = lcd_max(lcd_max(lcd_max(POWERUP_CYC, CLEAR_WAIT_CYC),
                                                      lcd_max(CMD_WAIT_CYC, EN_CYC)),
                                              lcd_max(SETUP_CYC, HOLD_CYC));
    localparam int unsigned CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] POWERUP_LD = CW'(POWERUP_CYC - 1);
    localparam logic [CW-1:0] SETUP_LD   = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LD      = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD    = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] CMD_LD     = CW'(CMD_WAIT_CYC - 1);
    localparam logic [CW-1:0] CLEAR_LD   = CW'(CLEAR_WAIT_CYC - 1);
    localparam logic [1:0]    LAST_IDX   = 2'(LCD_INIT_LEN - 1);

    lcd_state_t  state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic [1:0]  idx_q, idx_d;
    logic        done_q, done_d;
    logic        cnt_load;
    logic [CW-1:0] cnt_val;
    logic        cnt_done;

    lcd_delay_counter #(
        .W       (CW),
        .RST_VAL (POWERUP_LD)
    ) u_delay (
        .clk_i      (clk_clk),
        .rst_i      (reset_reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .done_o     (cnt_done)
    );

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        rs_d     = rs_q;
        idx_d    = idx_q;
        done_d   = done_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state_q)
            ST_POWERUP: begin
                if (cnt_done) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                data_d   = LCD_INIT_CMDS[idx_q];
                rs_d     = 1'b0;
                state_d  = ST_SETUP;
                cnt_load = 1'b1;
                cnt_val  = SETUP_LD;
            end
            ST_SETUP: begin
                if (cnt_done) begin
                    state_d  = ST_PULSE;
                    cnt_load = 1'b1;
                    cnt_val  = EN_LD;
                end
            end
            ST_PULSE: begin
                if (cnt_done) begin
                    state_d  = ST_HOLD;
                    cnt_load = 1'b1;
                    cnt_val  = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (cnt_done) begin
                    state_d  = ST_WAIT;
                    cnt_load = 1'b1;
                    cnt_val  = lcd_is_long_cmd(rs_q, data_q) ? CLEAR_LD : CMD_LD;
                end
            end
            ST_WAIT: begin
                if (cnt_done) begin
                    // The init index only advances while init bytes remain.
                    if (!done_q && (idx_q != LAST_IDX)) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_LOAD;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (req_valid) begin
                    data_d   = req_data;
                    rs_d     = req_rs;
                    state_d  = ST_SETUP;
                    cnt_load = 1'b1;
                    cnt_val  = SETUP_LD;
                end
            end
            default: begin
                state_d = ST_POWERUP;
            end
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= ST_POWERUP;
            data_q  <= '0;
            rs_q    <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign init_done = done_q;
    assign lcd_data  = data_q;
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = (state_q == ST_PULSE);

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Randomised self-checking bench: a schedule model of LCD writes predicts every
// output each cycle, backed by hand-computed timing literals for the test parameters.
module tb_lcd_write_sequencer;

    localparam int P  = 10;
    localparam int S  = 2;
    localparam int E  = 4;
    localparam int H  = 2;
    localparam int WC = 8;
    localparam int WL = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, init_done, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;

    lcd_write_sequencer #(
        .POWERUP_CYC    (P),
        .SETUP_CYC      (S),
        .EN_CYC         (E),
        .HOLD_CYC       (H),
        .CMD_WAIT_CYC   (WC),
        .CLEAR_WAIT_CYC (WL)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rs      (req_rs),
        .req_data    (req_data),
        .init_done   (init_done),
        .lcd_data    (lcd_data),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_en      (lcd_en)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    bit m_active = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, want);
        end
    endtask

    function automatic int wait_of(input logic rs, input logic [7:0] d);
        return (rs == 1'b0 && d >= 8'd1 && d <= 8'd3) ? WL : WC;
    endfunction

    function automatic int period_of(input logic rs, input logic [7:0] d);
        return S + E + H + wait_of(rs, d);
    endfunction

    always @(posedge clk) begin
        if (!m_active) cyc <= 0;
        else           cyc <= cyc + 1;
    end

    // Model: list of writes by the cycle their byte appears on the bus.
    int         w_start[$];
    logic [7:0] w_data[$];
    logic       w_rs[$];
    int         m_ready_at, m_done_at;
    bit         m_built = 1'b0;
    logic [7:0] init_bytes [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    always @(negedge clk) begin : model
        int st;
        logic [7:0] e_data;
        logic e_rs, e_en, e_rdy, e_done;
        if (!m_active) begin
            m_built = 1'b0;
        end else begin
            if (!m_built) begin
                w_start.delete(); w_data.delete(); w_rs.delete();
                st = P + 1;
                for (int k = 0; k < 4; k++) begin
                    w_start.push_back(st); w_data.push_back(init_bytes[k]); w_rs.push_back(1'b0);
                    st = st + period_of(1'b0, init_bytes[k]) + 1;
                end
                m_done_at  = st - 1;
                m_ready_at = m_done_at;
                m_built    = 1'b1;
            end
            e_data = 8'h00; e_rs = 1'b0; e_en = 1'b0;
            for (int i = 0; i < w_start.size(); i++) begin
                if (w_start[i] <= cyc) begin
                    e_data = w_data[i];
                    e_rs   = w_rs[i];
                end
                if (cyc >= w_start[i] + S && cyc < w_start[i] + S + E) e_en = 1'b1;
            end
            e_done = (cyc >= m_done_at);
            e_rdy  = e_done && (cyc >= m_ready_at);
            chk("lcd_data", lcd_data, e_data);
            chk("lcd_rs", lcd_rs, e_rs);
            chk("lcd_rw", lcd_rw, 1'b0);
            chk("lcd_en", lcd_en, e_en);
            chk("req_ready", req_ready, e_rdy);
            chk("init_done", init_done, e_done);
            if (e_rdy && req_valid) begin
                w_start.push_back(cyc + 1); w_data.push_back(req_data); w_rs.push_back(req_rs);
                m_ready_at = cyc + 1 + period_of(req_rs, req_data);
            end
        end
    end

    // Rising-edge log of EN with the byte on the bus at that moment.
    int         rise_cyc[$];
    logic [7:0] rise_dat[$];
    logic       prev_en = 1'b0;

    always @(negedge clk) begin
        if (!m_active) begin
            rise_cyc.delete(); rise_dat.delete();
            prev_en = 1'b0;
        end else begin
            if (lcd_en && !prev_en) begin
                rise_cyc.push_back(cyc);
                rise_dat.push_back(lcd_data);
            end
            prev_en = lcd_en;
        end
    end

    task automatic send(input logic rs, input logic [7:0] d, output int lat);
        int acc;
        bit got;
        lat = -1;
        got = 1'b0;
        acc = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_rs = rs; req_data = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin got = 1'b1; acc = cyc; break; end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!got) begin
            chk("accept_timeout", 1'b0, 1'b1);
            return;
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin lat = cyc - acc; return; end
            req_data = 8'($urandom);
            req_rs   = 1'($urandom);
        end
        chk("ready_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_init_done();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (init_done) break;
        end
        chk("init_done_cycle", cyc, 90);
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        m_active = 1'b1;
    endtask

    initial begin
        int lat, base, k;
        logic [7:0] b2b [5];
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_lcd_data", lcd_data, 8'h00);
        chk("rst_lcd_rs", lcd_rs, 1'b0);
        chk("rst_lcd_en", lcd_en, 1'b0);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_init_done", init_done, 1'b0);

        req_valid = 1'b1;
        release_reset();
        for (int i = 0; i < 60; i++) begin
            req_data = 8'($urandom);
            req_rs   = 1'($urandom);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        wait_init_done();
        chk("init_pulses", rise_cyc.size(), 4);
        if (rise_cyc.size() == 4) begin
            chk("init_rise0", rise_cyc[0], 13); chk("init_byte0", rise_dat[0], 8'h38);
            chk("init_rise1", rise_cyc[1], 30); chk("init_byte1", rise_dat[1], 8'h0C);
            chk("init_rise2", rise_cyc[2], 47); chk("init_byte2", rise_dat[2], 8'h01);
            chk("init_rise3", rise_cyc[3], 76); chk("init_byte3", rise_dat[3], 8'h06);
        end

        send(1'b1, 8'h41, lat); chk("lat_data_41", lat, 17);
        send(1'b0, 8'h02, lat); chk("lat_cmd_02", lat, 29);
        send(1'b0, 8'h80, lat); chk("lat_cmd_80", lat, 17);
        chk("bus_after_80", lcd_data, 8'h80);

        b2b  = '{8'hA1, 8'h3C, 8'h5E, 8'h77, 8'h90};
        base = rise_cyc.size();
        k = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_rs = 1'b1; req_data = b2b[0];
        for (int i = 0; i < 300 && k < 5; i++) begin
            @(negedge clk);
            if (req_ready) begin
                k++;
                @(posedge clk); #1;
                if (k < 5) req_data = b2b[k];
                else       req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        chk("b2b_accepts", k, 5);
        repeat (30) @(posedge clk);
        chk("b2b_pulses", rise_cyc.size() - base, 5);
        if (rise_cyc.size() - base == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("b2b_byte", rise_dat[base + i], b2b[i]);
                if (i > 0) chk("b2b_spacing", rise_cyc[base + i] - rise_cyc[base + i - 1], 17);
            end
        end

        for (int t = 0; t < 40; t++) begin
            logic [7:0] d;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            send(1'($urandom), d, lat);
        end

        @(posedge clk); #1;
        req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h48;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lcd_en) begin seen = 1'b1; break; end
        end
        chk("midreset_en_seen", seen, 1'b1);
        #2;
        m_active = 1'b0;
        rst = 1'b1;
        #1;
        chk("midreset_en", lcd_en, 1'b0);
        chk("midreset_init_done", init_done, 1'b0);
        chk("midreset_ready", req_ready, 1'b0);
        chk("midreset_data", lcd_data, 8'h00);
        repeat (3) @(posedge clk);
        req_valid = 1'b1; req_data = 8'hEE;
        release_reset();
        repeat (40) @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_init_done();
        chk("replay_pulses", rise_cyc.size(), 4);
        if (rise_cyc.size() > 0) begin
            chk("replay_rise0", rise_cyc[0], 13);
            chk("replay_byte0", rise_dat[0], 8'h38);
        end
        repeat (5) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
